mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the execute-stage results: effective address, store data or ALU result, opcode and destination register.
- For LW/SW it runs a valid/ready transaction on the data-memory port and stalls upstream until the transaction completes or times out.
- For every other opcode it registers the result into the MEM/WB slot.
- It is the one-entry MEM/WB pipeline register plus the data-memory request FSM.

Parameters:
- DATA_W, 16, datapath and address width.
- TIMEOUT, 255, maximum cycles mem_req is held without mem_ready before abort (1..2^CNT_W-1).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX/MEM slot holds an instruction.
- ex_opcode  in  4  instruction opcode.
- ex_addr  in  DATA_W  effective address, used for LW/SW only.
- ex_data  in  DATA_W  store data (SW) or ALU/LHB/LLB result.
- ex_rd  in  4  destination register.
- stall  out  1  upstream must hold ex_* and not advance.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (SW), 0 = read (LW).
- mem_addr  out  DATA_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data; valid when mem_req && mem_ready.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- wb_valid  out  1  one instruction retires this cycle (single-cycle pulse per instruction).
- wb_we  out  1  register-file write enable.
- wb_rd  out  4  register-file write address.
- wb_data  out  DATA_W  register-file write data.
- err  out  1  one-cycle pulse: misaligned access or timeout.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE; counter=0; stall, mem_req, mem_we, wb_valid, wb_we, err=0; mem_addr, mem_wdata, wb_rd, wb_data=0.
- Reset has priority over every event, including an in-flight request; mem_req falls at that edge and the transaction is abandoned with no retire.
- Opcode classes:
  - 1000 = LW.
  - 1001 = SW.
  - 0000–0111, 1010, 1011 = register-writing ALU ops.
  - 1100–1111 = non-writing; retire with wb_we=0.
- FSM states: IDLE, BUSY.
- stall = (state==BUSY); it is a registered-state decode, not combinational from mem_ready.
- Acceptance: an instruction is accepted at edge T when ex_valid=1 and state=IDLE.
- Non-memory op accepted at T:
  - At T+1: wb_valid=1, wb_rd=ex_rd, wb_data=ex_data, wb_we=1 for writing classes and 0 otherwise.
  - Latency 1, no stall.
- Misaligned LW/SW (ex_addr[0]=1) accepted at T:
  - No memory request.
  - At T+1: wb_valid=1, wb_we=0, err=1.
- Aligned LW/SW accepted at T:
  - At T+1: state=BUSY; mem_req=1; mem_we=(opcode==1001); mem_addr=ex_addr; mem_wdata=ex_data; counter=0.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- BUSY, completion (mem_ready=1 at edge E):
  - At E+1: mem_req=0, state=IDLE, wb_valid=1.
  - LW: wb_we=1, wb_data=mem_rdata sampled at E, wb_rd=latched rd.
  - SW: wb_we=0.
- BUSY, no mem_ready: counter increments each edge.
- BUSY, timeout: at the edge where counter==TIMEOUT-1 and mem_ready=0, abort.
  - At the next cycle: mem_req=0, state=IDLE, wb_valid=1, wb_we=0, err=1.
  - mem_ready arriving on the same edge as the timeout wins, and the transaction completes normally.
- No acceptance occurs while BUSY; the instruction waiting on ex_* is accepted at the first edge with state=IDLE.
  - With mem_ready already high, LW accepted at T gives stall high during T+1 only and retire at T+2.
- wb_valid, wb_we and err are 0 in every cycle not listed above.
- wb_rd and wb_data hold their last value when wb_valid=0.
- ex_valid=0 in IDLE: no retire, no state change.

Test Plan:
- ADD (0000), rd=3, data=0x1234, ex_valid for 1 cycle → next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=0x1234; stall never high.
- LW addr=0x0040, rd=5, mem_ready tied 1, mem_rdata=0xBEEF → mem_req/stall high exactly 1 cycle with mem_addr=0x0040, mem_we=0; retire 2 cycles after acceptance with wb_we=1, wb_data=0xBEEF.
- SW addr=0x0010, data=0xA5A5, mem_ready held low 4 cycles then high, followed by an ADD on ex_* → mem_req held 5 cycles with stable addr/wdata, mem_we=1; SW retires with wb_we=0; ADD retires exactly 1 cycle after SW retire.
- LW addr=0x0011 → no mem_req; next cycle wb_valid=1, wb_we=0, err=1.
- TIMEOUT=4, LW with mem_ready stuck low → mem_req high 4 cycles, then mem_req=0, err=1, wb_valid=1, wb_we=0; repeat with mem_ready rising on the 4th cycle → normal completion, err=0.
- LW in BUSY, rst_n low for 1 edge → mem_req, stall, wb_valid=0 the next cycle; no retire for the abandoned load; next ADD is accepted normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// MEM stage of the pipeline. Holds the one-entry MEM/WB register and the
// data-memory request FSM. Non-memory instructions retire one cycle after
// acceptance. LW/SW run a valid/ready transaction on the data-memory port,
// stalling upstream until the memory answers or the timeout counter expires.
// Misaligned LW/SW never reach memory and retire with an error pulse.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ex_valid          EX/MEM slot holds an instruction
//   ex_opcode         instruction opcode (1000 LW, 1001 SW, 11xx non-writing)
//   ex_addr           effective address (LW/SW)
//   ex_data           store data (SW) or ALU/LHB/LLB result
//   ex_rd             destination register
//   stall             upstream must hold ex_* (high while a request is pending)
//   mem_req/mem_we    memory request valid / write strobe
//   mem_addr          request address
//   mem_wdata         store data
//   mem_rdata         load data, valid when mem_req && mem_ready
//   mem_ready         memory accepts/completes the request this cycle
//   wb_valid          one instruction retires this cycle
//   wb_we/wb_rd       register-file write enable / write address
//   wb_data           register-file write data
//   err               one-cycle pulse on misaligned access or timeout

module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [3:0]        ex_rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [3:0]        req_rd, req_rd_nx;
  logic              mem_we_nx;
  logic [DATA_W-1:0] mem_addr_nx, mem_wdata_nx;
  logic              wb_valid_nx, wb_we_nx, err_nx;
  logic [3:0]        wb_rd_nx;
  logic [DATA_W-1:0] wb_data_nx;

  logic is_mem, is_sw, is_writing;

  // LW/SW share the 100x prefix; the 11xx group retires without a write.
  assign is_mem     = (ex_opcode[3:1] == 3'b100);
  assign is_sw      = (ex_opcode == 4'b1001);
  assign is_writing = (ex_opcode[3:2] != 2'b11);

  // The request is outstanding exactly while the FSM is BUSY, so both
  // outputs decode the registered state and never depend on mem_ready.
  assign stall   = (state == BUSY);
  assign mem_req = (state == BUSY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_rd    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_rd    <= req_rd_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      wb_valid  <= wb_valid_nx;
      wb_we     <= wb_we_nx;
      wb_rd     <= wb_rd_nx;
      wb_data   <= wb_data_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    req_rd_nx    = req_rd;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    wb_valid_nx  = 1'b0;
    wb_we_nx     = 1'b0;
    err_nx       = 1'b0;
    wb_rd_nx     = wb_rd;
    wb_data_nx   = wb_data;

    unique case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_nx = 1'b1;
            wb_we_nx    = is_writing;
            wb_rd_nx    = ex_rd;
            wb_data_nx  = ex_data;
          end else if (ex_addr[0]) begin
            wb_valid_nx = 1'b1;
            err_nx      = 1'b1;
            wb_rd_nx    = ex_rd;
          end else begin
            // Request fields are captured once so they stay stable for the
            // whole transaction even if ex_* changes.
            state_nx     = BUSY;
            cnt_nx       = '0;
            req_rd_nx    = ex_rd;
            mem_we_nx    = is_sw;
            mem_addr_nx  = ex_addr;
            mem_wdata_nx = ex_data;
          end
        end
      end
      BUSY: begin
        // mem_ready takes precedence over a timeout on the same edge.
        if (mem_ready) begin
          state_nx    = IDLE;
          wb_valid_nx = 1'b1;
          wb_rd_nx    = req_rd;
          if (!mem_we) begin
            wb_we_nx   = 1'b1;
            wb_data_nx = mem_rdata;
          end
        end else if (cnt == CNT_LAST) begin
          state_nx    = IDLE;
          wb_valid_nx = 1'b1;
          err_nx      = 1'b1;
          wb_rd_nx    = req_rd;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. Two instances share the clock, reset
// and ex_* payload: "dut" uses the default timeout, "dut_t4" uses TIMEOUT=4
// and only sees traffic during the timeout steps. Each retire expected from
// a stimulus step is pushed onto a per-instance queue; a negedge monitor pops
// and compares on every wb_valid, and flags stray err/wb_we pulses.

module tb_mem_access_unit;

  typedef struct {
    logic        we;
    logic [3:0]  rd;
    logic [15:0] data;
    logic        err;
    logic        chk_payload;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_a, ex_valid_b;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_addr, ex_data;
  logic [3:0]  ex_rd;
  logic [15:0] mem_rdata;
  logic        mem_ready_a, mem_ready_b;

  logic        stall_a, mem_req_a, mem_we_a, wb_valid_a, wb_we_a, err_a;
  logic [15:0] mem_addr_a, mem_wdata_a, wb_data_a;
  logic [3:0]  wb_rd_a;

  logic        stall_b, mem_req_b, mem_we_b, wb_valid_b, wb_we_b, err_b;
  logic [15:0] mem_addr_b, mem_wdata_b, wb_data_b;
  logic [3:0]  wb_rd_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  mem_access_unit #(.DATA_W(16), .TIMEOUT(255), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid_a), .ex_opcode(ex_opcode),
    .ex_addr(ex_addr), .ex_data(ex_data), .ex_rd(ex_rd), .stall(stall_a),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata), .mem_ready(mem_ready_a),
    .wb_valid(wb_valid_a), .wb_we(wb_we_a), .wb_rd(wb_rd_a),
    .wb_data(wb_data_a), .err(err_a)
  );

  mem_access_unit #(.DATA_W(16), .TIMEOUT(4), .CNT_W(8)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid_b), .ex_opcode(ex_opcode),
    .ex_addr(ex_addr), .ex_data(ex_data), .ex_rd(ex_rd), .stall(stall_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .mem_ready(mem_ready_b),
    .wb_valid(wb_valid_b), .wb_we(wb_we_b), .wb_rd(wb_rd_b),
    .wb_data(wb_data_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit to_b, input logic [3:0] op,
                               input logic [15:0] addr, input logic [15:0] data,
                               input logic [3:0] rd);
    ex_opcode = op;
    ex_addr   = addr;
    ex_data   = data;
    ex_rd     = rd;
    if (to_b) ex_valid_b = 1'b1;
    else      ex_valid_a = 1'b1;
  endtask

  function automatic exp_t mkExp(input logic we, input logic [3:0] rd,
                                 input logic [15:0] data, input logic e,
                                 input logic chk);
    exp_t x;
    x.we = we; x.rd = rd; x.data = data; x.err = e; x.chk_payload = chk;
    return x;
  endfunction

  task automatic checkRetire(input bit is_b, input logic v, input logic we,
                             input logic [3:0] rd, input logic [15:0] data,
                             input logic e);
    exp_t x;
    string p;
    p = is_b ? "t4_" : "a_";
    if (v) begin
      if ((is_b ? q_b.size() : q_a.size()) == 0) begin
        checkOutput({p, "retire_expected"}, 32'd0, 32'd1);
      end else begin
        x = is_b ? q_b.pop_front() : q_a.pop_front();
        checkOutput({p, "wb_we"}, 32'(we), 32'(x.we));
        checkOutput({p, "err"}, 32'(e), 32'(x.err));
        if (x.chk_payload) begin
          checkOutput({p, "wb_rd"}, 32'(rd), 32'(x.rd));
          checkOutput({p, "wb_data"}, 32'(data), 32'(x.data));
        end
      end
    end else begin
      checkOutput({p, "idle_wb_we"}, 32'(we), 32'd0);
      checkOutput({p, "idle_err"}, 32'(e), 32'd0);
    end
  endtask

  // Retire monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checkRetire(1'b0, wb_valid_a, wb_we_a, wb_rd_a, wb_data_a, err_a);
      checkRetire(1'b1, wb_valid_b, wb_we_b, wb_rd_b, wb_data_b, err_b);
    end
  end

  initial begin
    rst_n = 1'b0; ex_valid_a = 1'b0; ex_valid_b = 1'b0;
    ex_opcode = '0; ex_addr = '0; ex_data = '0; ex_rd = '0;
    mem_rdata = '0; mem_ready_a = 1'b0; mem_ready_b = 1'b0;
    tick(); tick();

    $display("[TB] reset state");
    checkOutput("rst_stall", 32'(stall_a), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req_a), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we_a), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid_a), 32'd0);
    checkOutput("rst_wb_we", 32'(wb_we_a), 32'd0);
    checkOutput("rst_wb_rd", 32'(wb_rd_a), 32'd0);
    checkOutput("rst_wb_data", 32'(wb_data_a), 32'd0);
    checkOutput("rst_err", 32'(err_a), 32'd0);
    checkOutput("rst_t4_mem_req", 32'(mem_req_b), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    $display("[TB] back-to-back ALU ops");
    applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h1234, 4'd3);
    q_a.push_back(mkExp(1'b1, 4'd3, 16'h1234, 1'b0, 1'b1));
    tick();
    checkOutput("add_stall", 32'(stall_a), 32'd0);
    checkOutput("add_wb_valid", 32'(wb_valid_a), 32'd1);
    applyStimulus(1'b0, 4'b1100, 16'h0000, 16'h5555, 4'd7);
    q_a.push_back(mkExp(1'b0, 4'd7, 16'h5555, 1'b0, 1'b1));
    tick();
    checkOutput("nw_stall", 32'(stall_a), 32'd0);
    applyStimulus(1'b0, 4'b1011, 16'h0000, 16'hF00D, 4'd10);
    q_a.push_back(mkExp(1'b1, 4'd10, 16'hF00D, 1'b0, 1'b1));
    tick();
    ex_valid_a = 1'b0;
    checkOutput("alu_stall", 32'(stall_a), 32'd0);
    tick();
    checkOutput("alu_idle_wb_valid", 32'(wb_valid_a), 32'd0);

    $display("[TB] LW with mem_ready already high");
    mem_ready_a = 1'b1;
    mem_rdata   = 16'hBEEF;
    applyStimulus(1'b0, 4'b1000, 16'h0040, 16'h0000, 4'd5);
    q_a.push_back(mkExp(1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1));
    tick();
    ex_valid_a = 1'b0;
    checkOutput("lw_mem_req", 32'(mem_req_a), 32'd1);
    checkOutput("lw_stall", 32'(stall_a), 32'd1);
    checkOutput("lw_mem_addr", 32'(mem_addr_a), 32'h0040);
    checkOutput("lw_mem_we", 32'(mem_we_a), 32'd0);
    checkOutput("lw_wb_valid_early", 32'(wb_valid_a), 32'd0);
    tick();
    mem_ready_a = 1'b0;
    checkOutput("lw_mem_req_drop", 32'(mem_req_a), 32'd0);
    checkOutput("lw_stall_drop", 32'(stall_a), 32'd0);
    checkOutput("lw_wb_data", 32'(wb_data_a), 32'hBEEF);
    tick();

    $display("[TB] SW with 4 wait cycles, ADD queued behind it");
    applyStimulus(1'b0, 4'b1001, 16'h0010, 16'hA5A5, 4'd2);
    q_a.push_back(mkExp(1'b0, 4'd2, 16'h0000, 1'b0, 1'b0));
    tick();
    applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0777, 4'd4);
    q_a.push_back(mkExp(1'b1, 4'd4, 16'h0777, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("sw_mem_req_%0d", i), 32'(mem_req_a), 32'd1);
      checkOutput($sformatf("sw_stall_%0d", i), 32'(stall_a), 32'd1);
      checkOutput($sformatf("sw_mem_we_%0d", i), 32'(mem_we_a), 32'd1);
      checkOutput($sformatf("sw_mem_addr_%0d", i), 32'(mem_addr_a), 32'h0010);
      checkOutput($sformatf("sw_mem_wdata_%0d", i), 32'(mem_wdata_a), 32'hA5A5);
      if (i == 4) mem_ready_a = 1'b1;
      tick();
    end
    mem_ready_a = 1'b0;
    checkOutput("sw_mem_req_drop", 32'(mem_req_a), 32'd0);
    checkOutput("sw_retire_valid", 32'(wb_valid_a), 32'd1);
    checkOutput("sw_retire_we", 32'(wb_we_a), 32'd0);
    tick();
    ex_valid_a = 1'b0;
    checkOutput("add_after_sw_valid", 32'(wb_valid_a), 32'd1);
    checkOutput("add_after_sw_rd", 32'(wb_rd_a), 32'd4);
    tick();

    $display("[TB] misaligned LW");
    applyStimulus(1'b0, 4'b1000, 16'h0011, 16'h0000, 4'd6);
    q_a.push_back(mkExp(1'b0, 4'd6, 16'h0000, 1'b1, 1'b0));
    tick();
    ex_valid_a = 1'b0;
    checkOutput("mis_mem_req", 32'(mem_req_a), 32'd0);
    checkOutput("mis_stall", 32'(stall_a), 32'd0);
    checkOutput("mis_err", 32'(err_a), 32'd1);
    tick();

    $display("[TB] timeout with TIMEOUT=4");
    applyStimulus(1'b1, 4'b1000, 16'h0020, 16'h0000, 4'd9);
    q_b.push_back(mkExp(1'b0, 4'd9, 16'h0000, 1'b1, 1'b0));
    tick();
    ex_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_mem_req_%0d", i), 32'(mem_req_b), 32'd1);
      tick();
    end
    checkOutput("to_mem_req_drop", 32'(mem_req_b), 32'd0);
    checkOutput("to_err", 32'(err_b), 32'd1);
    checkOutput("to_wb_we", 32'(wb_we_b), 32'd0);
    tick();

    $display("[TB] mem_ready on the timeout edge");
    mem_rdata = 16'h1357;
    applyStimulus(1'b1, 4'b1000, 16'h0020, 16'h0000, 4'd9);
    q_b.push_back(mkExp(1'b1, 4'd9, 16'h1357, 1'b0, 1'b1));
    tick();
    ex_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("late_mem_req_%0d", i), 32'(mem_req_b), 32'd1);
      if (i == 3) mem_ready_b = 1'b1;
      tick();
    end
    mem_ready_b = 1'b0;
    checkOutput("late_mem_req_drop", 32'(mem_req_b), 32'd0);
    checkOutput("late_err", 32'(err_b), 32'd0);
    tick();

    $display("[TB] reset during an outstanding LW");
    applyStimulus(1'b0, 4'b1000, 16'h0050, 16'h0000, 4'd1);
    tick();
    ex_valid_a = 1'b0;
    checkOutput("rst_busy_mem_req", 32'(mem_req_a), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rst_abandon_mem_req", 32'(mem_req_a), 32'd0);
    checkOutput("rst_abandon_stall", 32'(stall_a), 32'd0);
    checkOutput("rst_abandon_wb_valid", 32'(wb_valid_a), 32'd0);
    mem_ready_a = 1'b1;
    tick(); tick();
    mem_ready_a = 1'b0;
    applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h00AA, 4'd8);
    q_a.push_back(mkExp(1'b1, 4'd8, 16'h00AA, 1'b0, 1'b1));
    tick();
    ex_valid_a = 1'b0;
    checkOutput("post_rst_add_valid", 32'(wb_valid_a), 32'd1);
    tick(); tick();

    checkOutput("a_queue_drained", 32'(q_a.size()), 32'd0);
    checkOutput("t4_queue_drained", 32'(q_b.size()), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
